mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer.sv | 167 ++++++++++++++++
 tb/tb_mul_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mul_sequencer
// Description : Sequencer wrapped around an external unsigned multiplier array.
//               Turns each MUL/MULH/MULHSU/MULHU(/MULW) request into a pair of
//               operand magnitudes. It tracks each request through a LAT-deep
//               control pipeline and restores the sign of the returned product.
//               It then selects the requested half into a response register
//               that holds its value under backpressure.
//               Optional feature macro: MUL_RV64W_EN (adds MULW support).
// Revision    : 1.0 - initial release
// ============================================================================
module mul_sequencer #(
   parameter int XLEN  = 64,
   parameter int LAT   = 3,
   parameter int TAG_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [XLEN-1:0]   req_a,
   input  logic [XLEN-1:0]   req_b,
   input  logic [TAG_W-1:0]  req_tag,
   input  logic              flush,
   output logic              arr_en,
   output logic [XLEN-1:0]   arr_a,
   output logic [XLEN-1:0]   arr_b,
   input  logic [2*XLEN-1:0] arr_p,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_data,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              busy
);

   localparam logic [2:0] C_OP_MUL    = 3'b000;
   localparam logic [2:0] C_OP_MULH   = 3'b001;
   localparam logic [2:0] C_OP_MULHSU = 3'b010;
   localparam logic [2:0] C_OP_MULHU  = 3'b011;
`ifdef MUL_RV64W_EN
   localparam logic [2:0] C_OP_MULW   = 3'b100;
`endif

   // Handshake / flow control
   logic              w_stall;
   logic              w_arr_en;
   logic              w_req_ready;

   // Operand conditioning
   logic              w_a_signed;
   logic              w_b_signed;
   logic              w_sign_a;
   logic              w_sign_b;
   logic              w_neg;
   logic [XLEN-1:0]   w_mag_a;
   logic [XLEN-1:0]   w_mag_b;

   // Control pipeline, index 0 is the stage loaded on accept
   logic [LAT-1:0]    r_valid;
   logic [LAT-1:0]    r_neg;
   logic [TAG_W-1:0]  r_tag [LAT];
   logic [2:0]        r_op  [LAT];

   // Result path
   logic [2*XLEN-1:0] w_full;
   logic [XLEN-1:0]   w_result;
   logic              r_rsp_valid;
   logic [XLEN-1:0]   r_rsp_data;
   logic [TAG_W-1:0]  r_rsp_tag;

   // Whole pipeline freezes while a finished result waits for its consumer
   always_comb begin
      w_stall     = r_rsp_valid & ~rsp_ready;
      w_arr_en    = ~w_stall;
      w_req_ready = w_arr_en & ~flush;
   end

   assign arr_en    = w_arr_en;
   assign req_ready = w_req_ready;

   // Convert signed operands to magnitudes; the product sign is carried in neg
   always_comb begin
      w_a_signed = (req_op == C_OP_MULH) || (req_op == C_OP_MULHSU);
      w_b_signed = (req_op == C_OP_MULH);
      w_sign_a   = w_a_signed & req_a[XLEN-1];
      w_sign_b   = w_b_signed & req_b[XLEN-1];
      w_neg      = w_sign_a ^ w_sign_b;
      // The most negative value negates onto itself, which read unsigned is
      // exactly its magnitude 2^(XLEN-1).
      w_mag_a    = w_sign_a ? -req_a : req_a;
      w_mag_b    = w_sign_b ? -req_b : req_b;
`ifdef MUL_RV64W_EN
      if (req_op == C_OP_MULW) begin
         w_mag_a = {{(XLEN-32){1'b0}}, req_a[31:0]};
         w_mag_b = {{(XLEN-32){1'b0}}, req_b[31:0]};
      end
`endif
   end

   assign arr_a = w_mag_a;
   assign arr_b = w_mag_b;

   // Re-apply the sign to the array product and pick the requested slice
   always_comb begin
      w_full   = r_neg[LAT-1] ? -arr_p : arr_p;
      w_result = '0;
      case (r_op[LAT-1])
         C_OP_MUL:                          w_result = w_full[XLEN-1:0];
         C_OP_MULH, C_OP_MULHSU, C_OP_MULHU: w_result = w_full[2*XLEN-1:XLEN];
`ifdef MUL_RV64W_EN
         C_OP_MULW: w_result = {{(XLEN-32){w_full[31]}}, w_full[31:0]};
`endif
         default:                           w_result = '0;
      endcase
   end

   // Control shift register, moves in lockstep with the external array
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         r_neg   <= '0;
         for (int i = 0; i < LAT; i++) begin
            r_tag[i] <= '0;
            r_op[i]  <= '0;
         end
      end else if (flush) begin
         r_valid <= '0;
      end else if (w_arr_en) begin
         r_valid[0] <= req_valid & w_req_ready;
         r_neg[0]   <= w_neg;
         r_tag[0]   <= req_tag;
         r_op[0]    <= req_op;
         for (int i = 1; i < LAT; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_neg[i]   <= r_neg[i-1];
            r_tag[i]   <= r_tag[i-1];
            r_op[i]    <= r_op[i-1];
         end
      end
   end

   // Response register: a new load wins over a same-cycle consume, flush wins over both
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_tag   <= '0;
      end else if (flush) begin
         r_rsp_valid <= 1'b0;
      end else if (w_arr_en && r_valid[LAT-1]) begin
         r_rsp_valid <= 1'b1;
         r_rsp_data  <= w_result;
         r_rsp_tag   <= r_tag[LAT-1];
      end else if (r_rsp_valid && rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_tag   = r_rsp_tag;
   assign busy      = (|r_valid) | r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_sequencer
// Description : Self-checking bench for mul_sequencer with a behavioural
//               multiplier-array model and an arithmetic reference model.
//               Honours MUL_RV64W_EN for the MULW expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_sequencer;

   localparam int XLEN  = 64;
   localparam int LAT   = 3;
   localparam int TAG_W = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_op;
   logic [XLEN-1:0]   req_a;
   logic [XLEN-1:0]   req_b;
   logic [TAG_W-1:0]  req_tag;
   logic              flush;
   logic              arr_en;
   logic [XLEN-1:0]   arr_a;
   logic [XLEN-1:0]   arr_b;
   logic [2*XLEN-1:0] arr_p;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [XLEN-1:0]   rsp_data;
   logic [TAG_W-1:0]  rsp_tag;
   logic              busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mul_sequencer #(.XLEN(XLEN), .LAT(LAT), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .flush(flush),
      .arr_en(arr_en), .arr_a(arr_a), .arr_b(arr_b), .arr_p(arr_p),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_tag(rsp_tag), .busy(busy)
   );

   // External unsigned multiplier array: product appears LAT enabled cycles later
   logic [2*XLEN-1:0] pipe [LAT];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      end else if (arr_en) begin
         pipe[0] <= {{XLEN{1'b0}}, arr_a} * {{XLEN{1'b0}}, arr_b};
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign arr_p = pipe[LAT-1];

   // Architectural result computed with plain wide arithmetic
   function automatic logic [XLEN-1:0] ref_result(input logic [2:0] op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
      logic [2*XLEN-1:0] sa, sb, za, zb, p;
      sa = {{XLEN{a[XLEN-1]}}, a};
      sb = {{XLEN{b[XLEN-1]}}, b};
      za = {{XLEN{1'b0}}, a};
      zb = {{XLEN{1'b0}}, b};
      p  = '0;
      case (op)
         3'd0: begin p = za * zb; return p[XLEN-1:0]; end
         3'd1: begin p = sa * sb; return p[2*XLEN-1:XLEN]; end
         3'd2: begin p = sa * zb; return p[2*XLEN-1:XLEN]; end
         3'd3: begin p = za * zb; return p[2*XLEN-1:XLEN]; end
`ifdef MUL_RV64W_EN
         3'd4: begin
            p = {{(2*XLEN-32){1'b0}}, a[31:0]} * {{(2*XLEN-32){1'b0}}, b[31:0]};
            return {{(XLEN-32){p[31]}}, p[31:0]};
         end
`endif
         default: return '0;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] rand_operand();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return '1;
         2: return {1'b1, {(XLEN-1){1'b0}}};
         3: return {{(XLEN-1){1'b0}}, 1'b1};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b want=0", rsp_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
      checks++; if (rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
      checks++; if (rsp_tag !== '0) begin failures++; $display("FAIL reset_rsp_tag got=%h want=0", rsp_tag); end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0b want=1", req_ready); end
   endtask

   task automatic test_latency();
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd0; req_a = 64'd3; req_b = 64'd5; req_tag = 5'd7;
      rsp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL lat_accept got=%0b want=1", req_ready); end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         #1;
         checks++;
         if (rsp_valid !== (k == 4)) begin
            failures++; $display("FAIL lat_valid_cycle%0d got=%0b want=%0b", k, rsp_valid, (k == 4));
         end
      end
      checks++; if (rsp_data !== 64'd15) begin failures++; $display("FAIL lat_data got=%0d want=15", rsp_data); end
      checks++; if (rsp_tag !== 5'd7) begin failures++; $display("FAIL lat_tag got=%0d want=7", rsp_tag); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL lat_consumed got=%0b want=0", rsp_valid); end
   endtask

   task automatic test_signed_ops();
      logic [2:0]      ops  [5];
      logic [XLEN-1:0] as   [5];
      logic [XLEN-1:0] bs   [5];
      logic [XLEN-1:0] exps [5];
      logic            got;
      ops[0] = 3'd1; as[0] = '1;                    bs[0] = '1;                    exps[0] = '0;
      ops[1] = 3'd3; as[1] = '1;                    bs[1] = 64'd2;                 exps[1] = 64'd1;
      ops[2] = 3'd2; as[2] = '1;                    bs[2] = 64'd2;                 exps[2] = '1;
      ops[3] = 3'd1; as[3] = 64'h8000_0000_0000_0000; bs[3] = 64'h8000_0000_0000_0000;
      exps[3] = 64'h4000_0000_0000_0000;
      ops[4] = 3'd4; as[4] = 64'h1_0000_0002;       bs[4] = 64'h7FFF_FFFF;
`ifdef MUL_RV64W_EN
      exps[4] = 64'hFFFF_FFFF_FFFF_FFFE;
`else
      exps[4] = '0;
`endif
      rsp_ready = 1'b1;
      for (int v = 0; v < 5; v++) begin
         @(negedge clk);
         req_valid = 1'b1; req_op = ops[v]; req_a = as[v]; req_b = bs[v]; req_tag = 5'(v + 20);
         #1;
         checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL sign_accept%0d got=%0b want=1", v, req_ready); end
         @(negedge clk);
         req_valid = 1'b0;
         got = 1'b0;
         for (int k = 0; k < 10; k++) begin
            #1;
            if (rsp_valid === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
         end
         checks++;
         if (!got) begin
            failures++; $display("FAIL sign_timeout%0d got=no_response want=response", v);
         end else if (rsp_data !== exps[v] || rsp_tag !== 5'(v + 20)) begin
            failures++; $display("FAIL sign_vec%0d got=%h/%0d want=%h/%0d", v, rsp_data, rsp_tag, exps[v], v + 20);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [XLEN-1:0]  eq [$];
      logic [TAG_W-1:0] tq [$];
      int               seen;
      rsp_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req_valid = 1'b1; req_op = 3'($urandom_range(0, 3));
         req_a = rand_operand(); req_b = rand_operand(); req_tag = 5'(k + 10);
         #1;
         checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_accept%0d got=%0b want=1", k, req_ready); end
         eq.push_back(ref_result(req_op, req_a, req_b));
         tq.push_back(req_tag);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         #1;
         checks++;
         if (arr_en !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== eq[0]) begin
            failures++;
            $display("FAIL b2b_stall%0d got=en%0b rdy%0b v%0b d%h want=en0 rdy0 v1 d%h",
                     k, arr_en, req_ready, rsp_valid, rsp_data, eq[0]);
         end
      end
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         rsp_ready = 1'b1;
         #1;
         if (rsp_valid === 1'b1) begin
            checks++;
            if (eq.size() == 0) begin
               failures++; $display("FAIL b2b_extra got=%h want=none", rsp_data);
            end else begin
               if (rsp_data !== eq[0] || rsp_tag !== tq[0]) begin
                  failures++; $display("FAIL b2b_order%0d got=%h/%0d want=%h/%0d", seen, rsp_data, rsp_tag, eq[0], tq[0]);
               end
               void'(eq.pop_front()); void'(tq.pop_front());
            end
            seen++;
         end
      end
      checks++; if (seen != 4) begin failures++; $display("FAIL b2b_count got=%0d want=4", seen); end
   endtask

   task automatic test_flush();
      int spurious;
      rsp_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         req_valid = 1'b1; req_op = 3'd0; req_a = 64'd9; req_b = 64'd9; req_tag = 5'(k);
      end
      @(negedge clk);
      flush = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL flush_req_ready got=%0b want=0", req_ready); end
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%0b want=0", busy); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL flush_rsp_valid got=%0b want=0", rsp_valid); end
      spurious = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); #1;
         if (rsp_valid !== 1'b0) spurious++;
      end
      checks++; if (spurious != 0) begin failures++; $display("FAIL flush_no_rsp got=%0d want=0", spurious); end
   endtask

   task automatic test_reset_mid_stall();
      logic got;
      int   spurious;
      rsp_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         req_valid = 1'b1; req_op = 3'd0; req_a = 64'd6; req_b = 64'd7; req_tag = 5'(k + 3);
      end
      @(negedge clk);
      req_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (rsp_valid === 1'b1) begin got = 1'b1; break; end
         @(negedge clk);
      end
      checks++; if (!got) begin failures++; $display("FAIL rstmid_stall got=no_response want=response"); end
      rst = 1'b1;
      #1;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_rsp_valid got=%0b want=0", rsp_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b want=0", busy); end
      checks++;
      if (rsp_data !== '0 || rsp_tag !== '0) begin
         failures++; $display("FAIL rstmid_regs got=%h/%0d want=0/0", rsp_data, rsp_tag);
      end
      @(negedge clk);
      rst = 1'b0;
      rsp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_req_ready got=%0b want=1", req_ready); end
      spurious = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); #1;
         if (rsp_valid !== 1'b0) spurious++;
      end
      checks++; if (spurious != 0) begin failures++; $display("FAIL rstmid_no_rsp got=%0d want=0", spurious); end
   endtask

   task automatic test_random(input int n);
      logic [XLEN-1:0]  eq [$];
      logic [TAG_W-1:0] tq [$];
      for (int c = 0; c < n + 30; c++) begin
         @(negedge clk);
         if (c < n) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_op    = 3'($urandom_range(0, 7));
            req_a     = rand_operand();
            req_b     = rand_operand();
            req_tag   = 5'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
         end else begin
            req_valid = 1'b0; rsp_ready = 1'b1; flush = 1'b0;
         end
         #1;
         checks++;
         if (busy !== (eq.size() != 0)) begin
            failures++; $display("FAIL rand_busy cyc%0d got=%0b want=%0b", c, busy, (eq.size() != 0));
         end
         checks++;
         if (req_ready !== (!(rsp_valid && !rsp_ready) && !flush)) begin
            failures++; $display("FAIL rand_req_ready cyc%0d got=%0b want=%0b", c, req_ready,
                                 (!(rsp_valid && !rsp_ready) && !flush));
         end
         if (rsp_valid === 1'b1 && rsp_ready) begin
            checks++;
            if (eq.size() == 0) begin
               failures++; $display("FAIL rand_spurious cyc%0d got=%h want=none", c, rsp_data);
            end else begin
               if (rsp_data !== eq[0] || rsp_tag !== tq[0]) begin
                  failures++; $display("FAIL rand_result cyc%0d got=%h/%0d want=%h/%0d", c, rsp_data, rsp_tag, eq[0], tq[0]);
               end
               void'(eq.pop_front()); void'(tq.pop_front());
            end
         end
         if (flush) begin
            eq.delete(); tq.delete();
         end else if (req_valid && req_ready === 1'b1) begin
            eq.push_back(ref_result(req_op, req_a, req_b));
            tq.push_back(req_tag);
         end
      end
      checks++; if (eq.size() != 0) begin failures++; $display("FAIL rand_lost got=%0d want=0", eq.size()); end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
      req_tag = '0; flush = 1'b0; rsp_ready = 1'b0;
      test_reset();
      test_latency();
      test_signed_ops();
      test_back_to_back();
      test_flush();
      test_reset_mid_stall();
      test_random(600);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
